// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between instruction fetch and load/store, one access in flight.
// Grant->m_req 1 cycle, m_ack->ack 1 cycle (3 cycles min); losers wait with stall high; m_ack wait bounded by TIMEOUT.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int INSN_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [INSN_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic              i_m_ack,
  output logic              o_stall,
  output logic              o_timeout_err
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t            r_state;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [INSN_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_timeout_err;

  logic              w_gnt_d;
  logic              w_tmo;
  logic              w_fin;
  logic [DATA_W-1:0] w_cap;

  // On a tie the port that did not win last time goes first.
  assign w_gnt_d = i_d_req & (~i_if_req | (r_last == GNT_I));
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !i_m_ack;
  assign w_fin   = i_m_ack | w_tmo;
  assign w_cap   = i_m_ack ? i_m_rdata : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_last        <= GNT_I;
      r_cnt         <= '0;
      r_m_req       <= 1'b0;
      r_m_we        <= 1'b0;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_if_ack      <= 1'b0;
      r_d_ack       <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_if_req | i_d_req) begin
            r_last    <= w_gnt_d;
            r_cnt     <= '0;
            r_m_req   <= 1'b1;
            r_m_addr  <= w_gnt_d ? i_d_addr : i_if_addr;
            r_m_we    <= w_gnt_d & i_d_we;
            r_m_wdata <= w_gnt_d ? i_d_wdata : '0;
            r_state   <= w_gnt_d ? BUS_D : BUS_I;
          end
        end
        BUS_I, BUS_D: begin
          if (w_fin) begin
            r_m_req <= 1'b0;
            r_state <= RESP;
            if (w_tmo) r_timeout_err <= 1'b1;
            if (r_state == BUS_D) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= r_m_we ? '0 : w_cap;
            end else begin
              r_if_ack   <= 1'b1;
              // Word-aligned fetch: address bit 2 picks the half of the bus word.
              r_if_rdata <= r_m_addr[2] ? w_cap[INSN_W +: INSN_W] : w_cap[0 +: INSN_W];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_ack      = r_if_ack;
  assign o_if_rdata    = r_if_rdata;
  assign o_d_ack       = r_d_ack;
  assign o_d_rdata     = r_d_rdata;
  assign o_m_req       = r_m_req;
  assign o_m_we        = r_m_we;
  assign o_m_addr      = r_m_addr;
  assign o_m_wdata     = r_m_wdata;
  assign o_timeout_err = r_timeout_err;
  assign o_stall       = i_rst & ((i_if_req & ~r_if_ack) | (i_d_req & ~r_d_ack));

endmodule
